// File: rtl/hps_pixel_loader_if.sv
// rtl/hps_pixel_loader_if.sv - packed-word stream in, single-pixel RAM write port out
interface hps_pixel_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  pix_data;
   logic [14:0] pix_addr;
   logic        solicita_escrita;
   logic        done_write;

   // master is the loader side; slave is the HPS bridge plus RAM writer side
   modport master (
      input  s_data, s_valid, done_write,
      output s_ready, pix_data, pix_addr, solicita_escrita
   );
   modport slave (
      output s_data, s_valid, done_write,
      input  s_ready, pix_data, pix_addr, solicita_escrita
   );
endinterface

// File: rtl/hps_pixel_loader.sv
// rtl/hps_pixel_loader.sv - unpacks 32-bit HPS words into per-pixel original-image RAM writes
module hps_pixel_loader #(
   parameter int MEM_DEPTH      = 19200,
   parameter int GUARD_CYCLES   = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk_100,
   input  logic                 reset,
   input  logic                 cmd_start,
   input  logic [14:0]          cmd_base_addr,
   input  logic [15:0]          cmd_count,
   hps_pixel_loader_if.master   pix_if,
   output logic                 busy,
   output logic                 load_done,
   output logic                 err_range,
   output logic                 err_timeout,
   output logic [15:0]          pixels_written
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [16:0] DEPTH_W = 17'(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, FETCH, REQ, GUARD, DONE} state_t;

   state_t        state;
   logic [14:0]   base_q;
   logic [15:0]   count_q;
   logic [31:0]   word_q;
   logic [2:0]    byte_idx;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] guard_cnt;
   logic          range_bad;

   // 17-bit sum so a base near the top of the RAM cannot wrap past the check
   assign range_bad = ({2'b00, cmd_base_addr} + {1'b0, cmd_count}) > DEPTH_W;

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    pick_byte = w[7:0];
         2'd1:    pick_byte = w[15:8];
         2'd2:    pick_byte = w[23:16];
         default: pick_byte = w[31:24];
      endcase
   endfunction

   always_ff @(posedge clk_100 or negedge reset) begin
      if (!reset) begin
         state                   <= IDLE;
         base_q                  <= '0;
         count_q                 <= '0;
         word_q                  <= '0;
         byte_idx                <= '0;
         tmo_cnt                 <= '0;
         guard_cnt               <= '0;
         busy                    <= 1'b0;
         load_done               <= 1'b0;
         err_range               <= 1'b0;
         err_timeout             <= 1'b0;
         pixels_written          <= '0;
         pix_if.s_ready          <= 1'b0;
         pix_if.pix_data         <= '0;
         pix_if.pix_addr         <= '0;
         pix_if.solicita_escrita <= 1'b0;
      end else begin
         load_done <= 1'b0;
         err_range <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  if (cmd_count == 16'd0) begin
                     load_done      <= 1'b1;
                     pixels_written <= '0;
                     err_timeout    <= 1'b0;
                  end else if (range_bad) begin
                     err_range <= 1'b1;
                  end else begin
                     base_q         <= cmd_base_addr;
                     count_q        <= cmd_count;
                     pixels_written <= '0;
                     err_timeout    <= 1'b0;
                     busy           <= 1'b1;
                     pix_if.s_ready <= 1'b1;
                     state          <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (pix_if.s_valid) begin
                  word_q                  <= pix_if.s_data;
                  byte_idx                <= 3'd0;
                  pix_if.s_ready          <= 1'b0;
                  pix_if.solicita_escrita <= 1'b1;
                  pix_if.pix_data         <= pix_if.s_data[7:0];
                  pix_if.pix_addr         <= base_q + pixels_written[14:0];
                  tmo_cnt                 <= '0;
                  state                   <= REQ;
               end
            end
            REQ: begin
               if (pix_if.done_write) begin
                  pix_if.solicita_escrita <= 1'b0;
                  pixels_written          <= pixels_written + 16'd1;
                  byte_idx                <= byte_idx + 3'd1;
                  guard_cnt               <= '0;
                  state                   <= GUARD;
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  pix_if.solicita_escrita <= 1'b0;
                  err_timeout             <= 1'b1;
                  busy                    <= 1'b0;
                  state                   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GUARD: begin
               // late done_write pulses land here and are deliberately ignored
               if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                  if (pixels_written == count_q) begin
                     load_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else if (byte_idx == 3'd4) begin
                     pix_if.s_ready <= 1'b1;
                     state          <= FETCH;
                  end else begin
                     pix_if.solicita_escrita <= 1'b1;
                     pix_if.pix_data         <= pick_byte(word_q, byte_idx[1:0]);
                     pix_if.pix_addr         <= base_q + pixels_written[14:0];
                     tmo_cnt                 <= '0;
                     state                   <= REQ;
                  end
               end else begin
                  guard_cnt <= guard_cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hps_pixel_loader.sv
// tb/tb_hps_pixel_loader.sv - directed vector bench for hps_pixel_loader
module tb_hps_pixel_loader;
   logic        clk_100 = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [14:0] cmd_base_addr = '0;
   logic [15:0] cmd_count = '0;
   logic        busy, load_done, err_range, err_timeout;
   logic [15:0] pixels_written;

   hps_pixel_loader_if pif();

   hps_pixel_loader dut (
      .clk_100        (clk_100),
      .reset          (reset),
      .cmd_start      (cmd_start),
      .cmd_base_addr  (cmd_base_addr),
      .cmd_count      (cmd_count),
      .pix_if         (pif),
      .busy           (busy),
      .load_done      (load_done),
      .err_range      (err_range),
      .err_timeout    (err_timeout),
      .pixels_written (pixels_written)
   );

   always #5 clk_100 = ~clk_100;

   int total = 0;
   int bad = 0;

   // stream source
   logic [31:0] words [4];
   int  nwords = 0;
   int  hs_cnt = 0;
   int  hs_base = 0;
   bit  src_en = 1'b1;

   // write responder and logs
   bit          resp_en = 1'b1;
   int          age = 0;
   int          low_run = 100;
   bit          prev_sol = 1'b0;
   int          sol_high = 0;
   int          gap_viol = 0;
   int          nlog = 0;
   logic [14:0] log_addr [256];
   logic [7:0]  log_data [256];
   int          ld_cnt = 0;

   int ld0, log0, gv0, sh0;

   typedef struct {
      logic [14:0] base;
      logic [15:0] count;
      int          nw;
      logic [31:0] w0, w1, w2;
      logic [14:0] last_addr;
      logic [7:0]  last_data;
      int          hs;
   } vec_t;
   vec_t vt [4];

   initial begin
      forever begin
         @(negedge clk_100);
         if (src_en && (hs_cnt - hs_base) < nwords) begin
            pif.s_valid = 1'b1;
            pif.s_data  = words[hs_cnt - hs_base];
         end else begin
            pif.s_valid = 1'b0;
            pif.s_data  = '0;
         end
         if (pif.s_valid && pif.s_ready) hs_cnt++;
      end
   end

   // done_write arrives on the 4th cycle of each request
   initial begin
      forever begin
         @(negedge clk_100);
         pif.done_write = 1'b0;
         if (pif.solicita_escrita) begin
            if (!prev_sol && low_run < 3) gap_viol++;
            age++;
            sol_high++;
            low_run = 0;
            if (resp_en && age == 4) begin
               pif.done_write = 1'b1;
               if (nlog < 256) begin
                  log_addr[nlog] = pif.pix_addr;
                  log_data[nlog] = pif.pix_data;
                  nlog++;
               end
            end
         end else begin
            age = 0;
            low_run++;
         end
         prev_sol = pif.solicita_escrita;
      end
   end

   initial begin
      forever begin
         @(negedge clk_100);
         if (load_done) ld_cnt++;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic issue(input logic [14:0] b, input logic [15:0] c);
      @(negedge clk_100);
      cmd_base_addr = b;
      cmd_count     = c;
      cmd_start     = 1'b1;
      @(negedge clk_100);
      cmd_start     = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (ld_cnt == ld0 && !err_timeout && n < 3000) begin
         @(negedge clk_100);
         n++;
      end
      chk(name, longint'(n < 3000), 1);
   endtask

   task automatic prep(input int nw, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      words[0] = a;
      words[1] = b;
      words[2] = c;
      words[3] = '0;
      nwords   = nw;
      hs_base  = hs_cnt;
      log0     = nlog;
      ld0      = ld_cnt;
      gv0      = gap_viol;
   endtask

   initial begin
      vt[0] = '{15'd0,     16'd8,  2, 32'h04030201, 32'h08070605, 32'h0,        15'd7,     8'h08, 2};
      vt[1] = '{15'd100,   16'd5,  2, 32'h44332211, 32'h88776655, 32'h0,        15'd104,   8'h55, 2};
      vt[2] = '{15'd19190, 16'd10, 3, 32'h13121110, 32'h17161514, 32'h1b1a1918, 15'd19199, 8'h19, 3};
      vt[3] = '{15'd500,   16'd1,  1, 32'hDEADBEEF, 32'h0,        32'h0,        15'd500,   8'hEF, 1};

      #1 reset = 1'b0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_sol", pif.solicita_escrita, 0);
      chk("rst_ready", pif.s_ready, 0);
      chk("rst_pw", pixels_written, 0);
      chk("rst_errs", {load_done, err_range, err_timeout}, 0);
      repeat (2) @(negedge clk_100);
      reset = 1'b1;

      // zero count: load_done only
      prep(0, 0, 0, 0);
      issue(15'd10, 16'd0);
      chk("zero_load_done", load_done, 1);
      chk("zero_busy", busy, 0);
      @(negedge clk_100);
      chk("zero_load_done_low", load_done, 0);
      chk("zero_busy2", busy, 0);
      repeat (3) @(negedge clk_100);
      chk("zero_writes", nlog - log0, 0);

      // range reject: 19190 + 11 = 19201
      prep(1, 32'h11111111, 0, 0);
      issue(15'd19190, 16'd11);
      chk("range_err", err_range, 1);
      chk("range_busy", busy, 0);
      @(negedge clk_100);
      chk("range_err_low", err_range, 0);
      chk("range_ready", pif.s_ready, 0);
      repeat (5) @(negedge clk_100);
      chk("range_no_req", nlog - log0, 0);

      for (int v = 0; v < 4; v++) begin
         prep(vt[v].nw, vt[v].w0, vt[v].w1, vt[v].w2);
         issue(vt[v].base, vt[v].count);
         chk("fetch_ready", pif.s_ready, 1);
         chk("fetch_no_req", pif.solicita_escrita, 0);
         chk("busy_set", busy, 1);
         @(negedge clk_100);
         chk("first_req", pif.solicita_escrita, 1);
         chk("first_addr", pif.pix_addr, vt[v].base);
         wait_done("done_bound");
         chk("load_done_pulses", ld_cnt - ld0, 1);
         chk("pixels_written", pixels_written, vt[v].count);
         chk("writes", nlog - log0, vt[v].count);
         chk("handshakes", hs_cnt - hs_base, vt[v].hs);
         chk("guard_gap", gap_viol - gv0, 0);
         if (nlog - log0 == int'(vt[v].count)) begin
            for (int i = 0; i < int'(vt[v].count); i++) begin
               logic [31:0] w;
               w = words[i / 4];
               chk("pix_addr", log_addr[log0 + i], vt[v].base + 15'(i));
               chk("pix_data", log_data[log0 + i], 8'(w >> (8 * (i % 4))));
            end
            chk("last_addr", log_addr[nlog - 1], vt[v].last_addr);
            chk("last_data", log_data[nlog - 1], vt[v].last_data);
         end
         @(negedge clk_100);
         chk("idle_busy", busy, 0);
         chk("idle_pw_hold", pixels_written, vt[v].count);
      end

      // backpressure: no word for 20 cycles
      src_en = 1'b0;
      prep(1, 32'h0000BBAA, 0, 0);
      issue(15'd200, 16'd2);
      begin
         int unstable = 0;
         repeat (20) begin
            @(negedge clk_100);
            if (pif.s_ready !== 1'b1 || pif.solicita_escrita !== 1'b0 || busy !== 1'b1)
               unstable++;
         end
         chk("bp_stable", unstable, 0);
      end
      src_en = 1'b1;
      wait_done("bp_bound");
      chk("bp_writes", nlog - log0, 2);
      chk("bp_last_data", log_data[nlog - 1], 8'hBB);
      chk("bp_last_addr", log_addr[nlog - 1], 15'd201);

      // timeout: done_write never arrives
      resp_en = 1'b0;
      prep(1, 32'h01020304, 0, 0);
      sh0 = sol_high;
      issue(15'd300, 16'd4);
      wait_done("tmo_bound");
      @(negedge clk_100);
      chk("tmo_sol_cycles", sol_high - sh0, 255);
      chk("tmo_flag", err_timeout, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_no_done", ld_cnt - ld0, 0);
      chk("tmo_sol_low", pif.solicita_escrita, 0);
      resp_en = 1'b1;
      prep(1, 32'h01020304, 0, 0);
      issue(15'd300, 16'd4);
      chk("tmo_cleared", err_timeout, 0);
      wait_done("tmo_retry_bound");
      chk("tmo_retry_pw", pixels_written, 4);

      // reset during the third request
      prep(2, 32'h44434241, 32'h48474645, 0);
      issue(15'd400, 16'd8);
      begin
         int n = 0;
         while (!((nlog - log0) >= 2 && pif.solicita_escrita) && n < 500) begin
            @(negedge clk_100);
            n++;
         end
         chk("req3_bound", longint'(n < 500), 1);
      end
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_sol", pif.solicita_escrita, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pw", pixels_written, 0);
      @(negedge clk_100);
      reset = 1'b1;
      prep(1, 32'hCAFE1234, 0, 0);
      issue(15'd410, 16'd4);
      wait_done("post_rst_bound");
      chk("post_rst_pw", pixels_written, 4);
      chk("post_rst_writes", nlog - log0, 4);
      chk("post_rst_first", log_data[log0], 8'h34);
      chk("post_rst_last_data", log_data[nlog - 1], 8'hCA);
      chk("post_rst_last_addr", log_addr[nlog - 1], 15'd413);

      repeat (3) @(negedge clk_100);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
